// File: rtl/mux_rr_pipe.sv
// N-channel registered mux, manual or round-robin select; 1-cycle latency.
// Output slot accepts a new word only when empty or draining; otherwise all rReady low.
module mux_rr_pipe #(
  parameter int SIZE     = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       wMode,
  input  logic [SEL_W-1:0]           wSelect,
  input  logic [CHANNELS-1:0]        wValid,
  input  logic [CHANNELS*SIZE-1:0]   wData,
  output logic [CHANNELS-1:0]        rReady,
  output logic [SIZE-1:0]            rOut,
  output logic                       rOutValid,
  input  logic                       wOutReady,
  output logic [SEL_W-1:0]           rGrant
);

  logic [SIZE-1:0]  out_q, out_d;
  logic             vld_q, vld_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] cand_rr, cand;
  logic             found_rr, found_man, cand_vld;
  logic             free, xfer;

  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNELS) s = s - CHANNELS;
    return s[SEL_W-1:0];
  endfunction

  // First requester at or after the pointer, wrapping modulo CHANNELS.
  always_comb begin
    cand_rr  = '0;
    found_rr = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found_rr && wValid[wrap_idx(ptr_q, k)]) begin
        found_rr = 1'b1;
        cand_rr  = wrap_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    found_man = 1'b0;
    if (int'(wSelect) < CHANNELS) found_man = wValid[wSelect];
  end

  assign cand     = wMode ? cand_rr  : wSelect;
  assign cand_vld = wMode ? found_rr : found_man;
  assign free     = !vld_q || wOutReady;
  assign xfer     = cand_vld && free && !Reset;
  assign rReady   = xfer ? (CHANNELS'(1) << cand) : '0;

  always_comb begin
    out_d   = out_q;
    vld_d   = vld_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      out_d   = wData[int'(cand)*SIZE +: SIZE];
      grant_d = cand;
      vld_d   = 1'b1;
      // Manual transfers leave the pointer where round-robin left it.
      if (wMode) ptr_d = (int'(cand) == CHANNELS - 1) ? '0 : cand + 1'b1;
    end else if (vld_q && wOutReady) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_q   <= '0;
      vld_q   <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      out_q   <= out_d;
      vld_q   <= vld_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rOut      = out_q;
  assign rOutValid = vld_q;
  assign rGrant    = grant_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Randomized and directed bench for mux_rr_pipe against a behavioural model.
module tb_mux_rr_pipe;
  localparam int SZ = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             wMode;
  logic [SW-1:0]    wSelect;
  logic [CH-1:0]    wValid;
  logic [CH*SZ-1:0] wData;
  logic [CH-1:0]    rReady;
  logic [SZ-1:0]    rOut;
  logic             rOutValid;
  logic             wOutReady;
  logic [SW-1:0]    rGrant;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_out, m_grant, m_ptr;
  bit m_vld;

  mux_rr_pipe #(.SIZE(SZ), .CHANNELS(CH), .SEL_W(SW)) dut (
    .Clock(Clock), .Reset(Reset), .wMode(wMode), .wSelect(wSelect),
    .wValid(wValid), .wData(wData), .rReady(rReady), .rOut(rOut),
    .rOutValid(rOutValid), .wOutReady(wOutReady), .rGrant(rGrant)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_cand(input bit mode, input int sel, input bit [CH-1:0] vld, input int ptr);
    if (!mode) return (sel < CH && vld[sel]) ? sel : -1;
    for (int k = 0; k < CH; k++)
      if (vld[(ptr + k) % CH]) return (ptr + k) % CH;
    return -1;
  endfunction

  task automatic model_reset();
    m_out = 0; m_grant = 0; m_ptr = 0; m_vld = 0;
  endtask

  // One clock: drive inputs, check rReady, clock, check registered outputs.
  task automatic cyc(input bit mode, input int sel, input bit [CH-1:0] vld,
                     input bit ordy, input bit [CH*SZ-1:0] dat);
    int c;
    bit fr;
    logic [CH-1:0] exp_rdy;
    wMode = mode; wSelect = SW'(sel); wValid = vld; wOutReady = ordy; wData = dat;
    #1;
    c  = model_cand(mode, sel, vld, m_ptr);
    fr = !m_vld || ordy;
    exp_rdy = (fr && c >= 0) ? CH'(1 << c) : '0;
    chk("rReady", 32'(rReady), 32'(exp_rdy));
    @(posedge Clock);
    if (fr && c >= 0) begin
      m_out = int'(dat[c*SZ +: SZ]); m_grant = c; m_vld = 1;
      if (mode) m_ptr = (c + 1) % CH;
    end else if (m_vld && ordy) begin
      m_vld = 0;
    end
    #1;
    chk("rOutValid", 32'(rOutValid), 32'(m_vld));
    chk("rOut", 32'(rOut), 32'(m_out));
    chk("rGrant", 32'(rGrant), 32'(m_grant));
  endtask

  task automatic expect_grant(input string tag, input int g);
    chk(tag, 32'(rGrant), 32'(g));
  endtask

  function automatic bit [CH*SZ-1:0] rnd_data();
    bit [CH*SZ-1:0] d;
    for (int i = 0; i < CH; i++) d[i*SZ +: SZ] = SZ'($urandom);
    return d;
  endfunction

  task automatic do_reset();
    #2; Reset = 1'b1; #1;
    chk("rst_rOut", 32'(rOut), 32'h0);
    chk("rst_rOutValid", 32'(rOutValid), 32'h0);
    chk("rst_rReady", 32'(rReady), 32'h0);
    chk("rst_rGrant", 32'(rGrant), 32'h0);
    model_reset();
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  bit [CH*SZ-1:0] d;

  initial begin
    Reset = 1'b1; wMode = 0; wSelect = 0; wValid = 0; wOutReady = 0; wData = '0;
    model_reset();
    #2;
    chk("init_rOutValid", 32'(rOutValid), 32'h0);
    chk("init_rReady", 32'(rReady), 32'h0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    // Manual select of channel 2
    d = rnd_data(); d[2*SZ +: SZ] = 8'hA5;
    cyc(0, 2, 4'b1111, 1, d);
    chk("man_rOut_A5", 32'(rOut), 32'hA5);
    expect_grant("man_grant2", 2);
    cyc(0, 1, 4'b1101, 1, rnd_data());   // selected channel not valid: drain only
    chk("man_novalid_drain", 32'(rOutValid), 32'h0);

    // Reset mid-cycle while holding a word, with inputs requesting
    cyc(1, 0, 4'b1111, 0, rnd_data());
    wOutReady = 1'b1;
    do_reset();

    // Round-robin fairness, all requesting
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 4'b1111, 1, rnd_data());
      expect_grant("rr_fair", i % 4);
      chk("rr_fair_vld", 32'(rOutValid), 32'h1);
    end

    // Round-robin skip with pointer at 1
    do_reset();
    cyc(1, 0, 4'b0001, 1, rnd_data());
    expect_grant("skip_seed", 0);
    cyc(1, 0, 4'b1001, 1, rnd_data()); expect_grant("skip_a", 3);
    cyc(1, 0, 4'b1001, 1, rnd_data()); expect_grant("skip_b", 0);
    cyc(1, 0, 4'b1001, 1, rnd_data()); expect_grant("skip_c", 3);

    // Back-pressure then simultaneous drain+load of channel 1
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'b0010, 0, rnd_data());
      expect_grant("bp_hold", 3);
    end
    d = rnd_data(); d[1*SZ +: SZ] = 8'h3C;
    cyc(1, 0, 4'b0010, 1, d);
    expect_grant("bp_load", 1);
    chk("bp_rOut", 32'(rOut), 32'h3C);
    chk("bp_vld", 32'(rOutValid), 32'h1);

    // Mode switch mid-stream keeps the pointer
    do_reset();
    cyc(1, 0, 4'b1111, 1, rnd_data()); expect_grant("ms_0", 0);
    cyc(1, 0, 4'b1111, 1, rnd_data()); expect_grant("ms_1", 1);
    cyc(0, 3, 4'b1111, 1, rnd_data()); expect_grant("ms_man3", 3);
    cyc(1, 0, 4'b1111, 1, rnd_data()); expect_grant("ms_rr2", 2);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom), int'($urandom_range(0, CH - 1)), CH'($urandom),
          ($urandom_range(0, 3) != 0), rnd_data());
    end
    do_reset();
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom), int'($urandom_range(0, CH - 1)), CH'($urandom),
          1'($urandom), rnd_data());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
